// File: rtl/acorn128_pkg.sv
// Shared ACORN-128 constants, FSM encoding and the bit-exact step/keystream functions
// used by the initialization, encryption and decryption blocks.
package acorn128_pkg;

  localparam int unsigned STATE_W   = 293;
  localparam int unsigned BLOCK_W   = 128;
  localparam int unsigned PAD_STEPS = 256;

  typedef enum logic [1:0] {StIdle, StData, StPad, StDone} acorn_fsm_e;

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic ch(input logic a, input logic b, input logic c);
    return (a & b) ^ (~a & c);
  endfunction

  // The six LFSR tap updates; order matters, each reads a not-yet-updated tap.
  function automatic logic [STATE_W-1:0] acorn_lin(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] t;
    t      = s;
    t[289] = t[289] ^ t[235] ^ t[230];
    t[230] = t[230] ^ t[196] ^ t[193];
    t[193] = t[193] ^ t[160] ^ t[154];
    t[154] = t[154] ^ t[111] ^ t[107];
    t[107] = t[107] ^ t[66]  ^ t[61];
    t[61]  = t[61]  ^ t[23]  ^ t[0];
    return t;
  endfunction

  function automatic logic acorn_ks(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] t;
    t = acorn_lin(s);
    return t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);
  endfunction

  function automatic logic [STATE_W-1:0] acorn_step(input logic [STATE_W-1:0] s,
                                                    input logic m, input logic ca,
                                                    input logic cb);
    logic [STATE_W-1:0] t;
    logic               ks;
    logic               f;
    t  = acorn_lin(s);
    ks = acorn_ks(s);
    f  = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks);
    return {f ^ m, t[STATE_W-1:1]};
  endfunction

endpackage

// File: rtl/acorn128_step.sv
// Combinational single ACORN-128 step: next state plus the keystream bit of the current state.
module acorn128_step
  import acorn128_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  input  logic               m_i,
  input  logic               ca_i,
  input  logic               cb_i,
  output logic [STATE_W-1:0] next_state_o,
  output logic               ks_o
);

  // ks depends only on the state, so callers may fold it into m without a loop.
  assign ks_o         = acorn_ks(state_i);
  assign next_state_o = acorn_step(state_i, m_i, ca_i, cb_i);

endmodule

// File: rtl/acorn128_decryption.sv
// Bit-serial ACORN-128 decryption: 128 data steps recovering plaintext, then 256 pad steps.
module acorn128_decryption
  import acorn128_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] state_in,
  input  logic [BLOCK_W-1:0] cipher_in,
  output logic               busy,
  output logic               done,
  output logic [BLOCK_W-1:0] plain_out,
  output logic [STATE_W-1:0] state_out
);

  acorn_fsm_e         fsm_q, fsm_d;
  logic [8:0]         cnt_q;
  logic [STATE_W-1:0] state_q;
  logic [BLOCK_W-1:0] cipher_q;
  logic [BLOCK_W-1:0] plain_q;
  logic               done_q, done_d;

  logic               accept, last_data, last_pad;
  logic               step_m, step_ca, ks;
  logic [STATE_W-1:0] state_next;

  assign accept    = start && (fsm_q == StIdle || fsm_q == StDone);
  assign last_data = (cnt_q == 9'd127);
  assign last_pad  = (cnt_q == 9'd255);

  acorn128_step u_step (
    .state_i      (state_q),
    .m_i          (step_m),
    .ca_i         (step_ca),
    .cb_i         (1'b0),
    .next_state_o (state_next),
    .ks_o         (ks)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= StIdle;
    else     fsm_q <= fsm_d;
  end

  // Next-state logic
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      StIdle: if (start) fsm_d = StData;
      StData: if (last_data) fsm_d = StPad;
      StPad:  if (last_pad) fsm_d = StDone;
      StDone: fsm_d = start ? StData : StIdle;
    endcase
  end

  // Output / step-control logic
  always_comb begin
    busy    = (fsm_q == StData) || (fsm_q == StPad);
    done_d  = (fsm_q == StPad) && last_pad;
    // Data phase absorbs the recovered plaintext bit, pad phase a single leading 1.
    step_m  = (fsm_q == StData) ? (cipher_q[cnt_q[6:0]] ^ ks) : (cnt_q == 9'd0);
    step_ca = (fsm_q == StData) ? 1'b1 : ~cnt_q[7];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      state_q  <= '0;
      cipher_q <= '0;
      plain_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= done_d;
      if (accept) begin
        cnt_q    <= '0;
        state_q  <= state_in;
        cipher_q <= cipher_in;
        plain_q  <= '0;
      end else if (fsm_q == StData) begin
        state_q              <= state_next;
        plain_q[cnt_q[6:0]]  <= step_m;
        cnt_q                <= last_data ? 9'd0 : cnt_q + 9'd1;
      end else if (fsm_q == StPad) begin
        state_q <= state_next;
        cnt_q   <= last_pad ? 9'd0 : cnt_q + 9'd1;
      end
    end
  end

  assign done      = done_q;
  assign plain_out = plain_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_acorn128_decryption.sv
// Self-checking bench for acorn128_decryption against a bit-level ACORN-128 reference model.
module tb_acorn128_decryption;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [292:0] state_in;
  logic [127:0] cipher_in;
  logic         busy;
  logic         done;
  logic [127:0] plain_out;
  logic [292:0] state_out;

  int  checks = 0;
  int  failures = 0;
  time done_t;

  acorn128_decryption dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .state_in  (state_in),
    .cipher_in (cipher_in),
    .busy      (busy),
    .done      (done),
    .plain_out (plain_out),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: one ACORN-128 step in the style of the published C code.
  // in_bit is plaintext when encrypting, ciphertext when decrypting; out_bit = in_bit ^ ks.
  task automatic ref_step(inout bit [292:0] s, input bit in_bit, input bit dec,
                          input bit ca, input bit cb, output bit out_bit);
    bit ks, f, m;
    s[289] ^= s[235] ^ s[230];
    s[230] ^= s[196] ^ s[193];
    s[193] ^= s[160] ^ s[154];
    s[154] ^= s[111] ^ s[107];
    s[107] ^= s[66]  ^ s[61];
    s[61]  ^= s[23]  ^ s[0];
    ks = s[12] ^ s[154] ^ ((s[235] & s[61]) ^ (s[235] & s[193]) ^ (s[61] & s[193]))
         ^ ((s[230] & s[111]) ^ (~s[230] & s[66]));
    f  = s[0] ^ ~s[107] ^ ((s[244] & s[23]) ^ (s[244] & s[160]) ^ (s[23] & s[160]))
         ^ (ca & s[196]) ^ (cb & ks);
    m  = dec ? (in_bit ^ ks) : in_bit;
    for (int j = 0; j < 292; j++) s[j] = s[j+1];
    s[292]  = f ^ m;
    out_bit = in_bit ^ ks;
  endtask

  task automatic ref_run(input bit [292:0] s_in, input bit [127:0] din, input bit dec,
                         output bit [127:0] dout, output bit [292:0] s_out);
    bit [292:0] s;
    bit         o;
    s = s_in;
    for (int i = 0; i < 128; i++) begin
      ref_step(s, din[i], dec, 1'b1, 1'b0, o);
      dout[i] = o;
    end
    for (int j = 0; j < 256; j++) ref_step(s, (j == 0), 1'b0, (j < 128), 1'b0, o);
    s_out = s;
  endtask

  function automatic logic [292:0] rand_state();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r[292:0];
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one start, optionally pulses start again at cycle ignore_at, waits for done.
  task automatic run_block(input logic [292:0] s, input logic [127:0] c, input int ignore_at,
                           output int lat);
    start = 1'b1; state_in = s; cipher_in = c;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge clk); #1;
      start = (n == ignore_at);
      if (n == ignore_at) begin
        state_in = rand_state(); cipher_in = rand_block();
      end
      if (done) begin
        lat = n; done_t = $time;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [127:0] ep, input logic [292:0] es);
    checks++;
    if (plain_out !== ep) begin
      failures++; $display("FAIL %s_plain: got %h want %h", name, plain_out, ep);
    end
    checks++;
    if (state_out !== es) begin
      failures++; $display("FAIL %s_state: got %h want %h", name, state_out, es);
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (plain_out !== '0) begin failures++; $display("FAIL reset_plain: got %h want 0", plain_out); end
    checks++; if (state_out !== '0) begin failures++; $display("FAIL reset_state: got %h want 0", state_out); end
  endtask

  task automatic test_zero_state();
    bit [127:0] ep; bit [292:0] es; int lat;
    ref_run('0, 128'h1, 1'b1, ep, es);
    run_block('0, 128'h1, -1, lat);
    checks++; if (lat !== 384) begin failures++; $display("FAIL zero_latency: got %0d want 384", lat); end
    checks++; if (plain_out[0] !== 1'b1) begin failures++; $display("FAIL zero_plain0: got %b want 1", plain_out[0]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_at_done: got %b want 0", busy); end
    check_result("zero", ep, es);
  endtask

  task automatic test_round_trip();
    bit [292:0] s0, es_enc, es_dec; bit [127:0] pt, ct, ep; int lat;
    s0 = rand_state();
    pt = 128'h0123456789ABCDEF_FEDCBA9876543210;
    ref_run(s0, pt, 1'b0, ct, es_enc);
    ref_run(s0, ct, 1'b1, ep, es_dec);
    run_block(s0, ct, -1, lat);
    checks++; if (lat !== 384) begin failures++; $display("FAIL rt_latency: got %0d want 384", lat); end
    check_result("rt", pt, es_enc);
  endtask

  task automatic test_start_ignored();
    bit [292:0] s, es; bit [127:0] c, ep; int lat;
    s = rand_state(); c = rand_block();
    ref_run(s, c, 1'b1, ep, es);
    run_block(s, c, 100, lat);
    checks++; if (lat !== 384) begin failures++; $display("FAIL ign_latency: got %0d want 384", lat); end
    check_result("ign", ep, es);
  endtask

  task automatic test_reset_abort();
    bit [292:0] s, es; bit [127:0] c, ep; int lat, seen;
    s = rand_state(); c = rand_block();
    start = 1'b1; state_in = s; cipher_in = c;
    @(posedge clk); #1; start = 1'b0;
    repeat (128 + 50) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL abort_ctl: got %b want 00", {busy, done}); end
    checks++; if (plain_out !== '0) begin failures++; $display("FAIL abort_plain: got %h want 0", plain_out); end
    checks++; if (state_out !== '0) begin failures++; $display("FAIL abort_state: got %h want 0", state_out); end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (400) begin @(posedge clk); #1; if (done || busy) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_done: got %0d want 0", seen); end
    ref_run(s, c, 1'b1, ep, es);
    run_block(s, c, -1, lat);
    checks++; if (lat !== 384) begin failures++; $display("FAIL abort_rerun_latency: got %0d want 384", lat); end
    check_result("abort_rerun", ep, es);
  endtask

  task automatic test_back_to_back();
    bit [292:0] s1, s2, es1, es2; bit [127:0] c1, c2, ep1, ep2; int lat; time t1;
    s1 = rand_state(); c1 = rand_block(); s2 = rand_state(); c2 = rand_block();
    ref_run(s1, c1, 1'b1, ep1, es1);
    ref_run(s2, c2, 1'b1, ep2, es2);
    run_block(s1, c1, -1, lat);
    t1 = done_t;
    check_result("b2b_first", ep1, es1);
    run_block(s2, c2, -1, lat);
    checks++;
    if ((done_t - t1) / 10 !== 385) begin
      failures++; $display("FAIL b2b_gap: got %0d want 385", (done_t - t1) / 10);
    end
    check_result("b2b_second", ep2, es2);
  endtask

  task automatic test_bit_flip();
    bit [292:0] s, es_ref, es_flip; bit [127:0] c, ep_ref, ep_flip, cf; int lat; int k;
    s = rand_state(); c = rand_block();
    ref_run(s, c, 1'b1, ep_ref, es_ref);
    for (int t = 0; t < 3; t++) begin
      k = (t == 0) ? 0 : (t == 1) ? 64 : 127;
      cf = c; cf[k] = ~cf[k];
      ref_run(s, cf, 1'b1, ep_flip, es_flip);
      run_block(s, cf, -1, lat);
      checks++;
      if (plain_out[k] !== ~ep_ref[k]) begin
        failures++; $display("FAIL flip%0d_bit: got %b want %b", k, plain_out[k], ~ep_ref[k]);
      end
      checks++;
      if (state_out === es_ref) begin
        failures++; $display("FAIL flip%0d_state_differs: got %h want not %h", k, state_out, es_ref);
      end
      check_result($sformatf("flip%0d", k), ep_flip, es_flip);
    end
  endtask

  task automatic test_random();
    bit [292:0] s, es; bit [127:0] c, ep; int lat;
    for (int i = 0; i < 3; i++) begin
      s = rand_state(); c = rand_block();
      ref_run(s, c, 1'b1, ep, es);
      run_block(s, c, -1, lat);
      check_result($sformatf("rand%0d", i), ep, es);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; state_in = '0; cipher_in = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    test_zero_state();
    test_round_trip();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_bit_flip();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acorn128_decryption.md
# acorn128_decryption

Bit-serial ACORN-128 decryption core: the receive-side counterpart of the encryption block. It takes a 293-bit cipher state, already initialized with key/IV and with associated data absorbed, plus one 128-bit ciphertext block. It recovers the plaintext one bit per clock, applies the 256-step message padding, and presents the updated state to the downstream tag/finalization stage. Its step schedule and bit ordering match the encryption path exactly, so an encrypt→decrypt pair from the same state yields identical final states.

## Interface
- No parameters; widths are fixed by ACORN-128 (state 293, block 128).
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE or DONE
- state_in  in  293  cipher state at message start; captured on the accepting start
- cipher_in  in  128  ciphertext block, bit i processed at step i (LSB first); captured on start
- busy  out  1  high in DATA and PAD
- done  out  1  one-cycle pulse; plain_out and state_out are valid from this cycle until the next accepted start
- plain_out  out  128  recovered plaintext, bit i = cipher bit i ^ ks(step i)
- state_out  out  293  state after the last pad step

## Operation
- FSM states and transitions:
  - IDLE → DATA on start.
  - DATA → PAD after 128 steps.
  - PAD → DONE after 256 steps.
  - DONE → DATA on start; otherwise DONE → IDLE.
- A 9-bit step counter counts 0..127 in DATA and 0..255 in PAD, and clears on each phase change.
- Each DATA/PAD cycle performs exactly one ACORN-128 step on the state register:
  - ks = acorn_ks(S).
  - m is selected per phase.
  - S ← acorn_step(S, m, ca, cb).
- DATA step i:
  - m = cipher_r[i] ^ ks; plain_r[i] ← m.
  - ca = 1, cb = 0.
  - The state absorbs the plaintext bit m, not the ciphertext bit.
- PAD step j:
  - m = 1 when j = 0, else 0.
  - ca = 1 for j ≤ 127, 0 for j ≥ 128.
  - cb = 0.
- Reset values: every register is 0, so busy = 0, done = 0, plain_out = 0, state_out = 0, and the FSM is in IDLE.
- start while busy is ignored and the in-flight operation is unaffected.
- Outputs hold their values after done and are not cleared until the next accepted start, at which point plain_r is cleared.
- Assertion of rst at any time aborts immediately. done is not produced for an aborted block.
- No tag comparison is done here; tag verification belongs to the finalization block.

## Timing
- start accepted at edge E0:
  - state_r ← state_in, cipher_r ← cipher_in.
  - busy is high from E0.
- DATA steps occur on edges E1..E128; PAD steps occur on edges E129..E384.
- done is high and busy low in the cycle after E384, i.e. 384 clocks after acceptance. done drops at E385.
- Back-to-back operation: start in the done cycle is accepted at E385, so throughput is one block per 385 cycles.
- plain_out[i] becomes final after edge E(i+1).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package acorn128_pkg holds the constants and functions:
  - Constants: STATE_W = 293, BLOCK_W = 128, PAD_STEPS = 256.
  - Functions acorn_ks(S) and acorn_step(S, m, ca, cb), the LFSR taps, maj/ch and feedback, shared bit-exact with the encryption and initialization blocks.
  - Enum for the FSM states.
- One natural sub-module: acorn128_step, a combinational single step (state, m, ca, cb → next state, ks). The same instance is reused by the encryption path.

## Test plan
- All-zero state_in, cipher_in = 0x1 → plain_out[0] = 1 (ks0 of the zero state is 0); done occurs exactly 384 cycles after start.
- Round trip:
  - Encrypt plaintext 0x0123456789ABCDEF_FEDCBA9876543210 from a fixed state S0 using the encryption block.
  - Decrypt the result from S0.
  - plain_out equals the original plaintext, and state_out equals the encryption path's post-pad state.
- start pulsed at cycle 100 of a block → ignored; results and done timing are identical to an undisturbed run.
- rst asserted during PAD step 50 → all outputs become 0 asynchronously and the FSM returns to IDLE with no done pulse. A subsequent start gives correct results.
- start in the done cycle with a second block → accepted; second done 385 cycles after the first; both results match the C model.
- Single-bit flip of cipher_in[k] for k = 0, 64 and 127 → plain_out[k] flips and state_out differs from the reference run.
